pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Parametrised next-generation program counter for the MIPS fetch stage.
//   Holds the PC register and selects the next PC from a prioritised set of
//   redirect sources (flush, return, jump, branch, sequential).
//   Adds a RAS_DEPTH-entry circular return-address stack so JR $31 resolves
//   at fetch. Feeds the icache address and IF/ID pc_plus.
// PARAMETERS
//   WORD_W    32     width of PC and all target buses
//   PC_RESET  0      PC value loaded on reset
//   PC_INC    4      sequential increment (byte address)
//   RAS_DEPTH 4      return-stack entries, power of two, >= 2
// PORTS
//   CLK           in   1       clock, rising edge
//   RST           in   1       asynchronous, active-high reset
//   pcWEN         in   1       1 = PC may advance; 0 = stall (hold)
//   flush_en      in   1       exception/mispredict redirect
//   flush_target  in   WORD_W  flush destination
//   ret_en        in   1       JR $31: redirect to return address
//   ret_fallback  in   WORD_W  $31 value, used when RAS empty
//   jump_en       in   1       J/JAL redirect
//   jump_target   in   WORD_W  jump destination
//   call_en       in   1       JAL: push pc_out+PC_INC (with jump_en)
//   branch_en     in   1       taken branch redirect
//   branch_target in   WORD_W  branch destination
//   pc_out        out  WORD_W  current PC
//   pc_plus       out  WORD_W  pc_out + PC_INC (combinational)
//   ras_count     out  $clog2(RAS_DEPTH)+1  valid RAS entries
//   ras_ovf       out  1       sticky: a push overwrote the oldest entry
// BEHAVIOUR
//   Reset (async, RST=1): pc_out=PC_RESET, ras_count=0, RAS pointer=0,
//     ras_ovf=0; RAS contents don't-care. Release takes effect next edge.
//   pc_plus = pc_out + PC_INC, mod 2^WORD_W (wraps, no flag).
//   Next-PC priority at each rising edge:
//     1 flush_en      -> flush_target (applies even if pcWEN=0)
//     2 ret_en        -> RAS top if ras_count>0 else ret_fallback
//     3 jump_en       -> jump_target
//     4 branch_en     -> branch_target
//     5 none          -> pc_plus
//   Sources 2-5 act only when pcWEN=1; with pcWEN=0 and no flush, PC and
//   RAS hold regardless of other inputs.
//   One-cycle latency: redirect asserted in cycle n appears on pc_out n+1.
//   RAS: circular buffer, ptr = index of next free slot.
//     push (call_en & jump_en & pcWEN & !flush_en & !ret_en): write
//       pc_plus at ptr, ptr++ (wraps mod RAS_DEPTH); count saturates at
//       RAS_DEPTH; push when full overwrites oldest and sets ras_ovf.
//     pop (ret_en & pcWEN & !flush_en & count>0): ptr--, count--.
//       Pop when empty: no pointer change, fallback used.
//     call_en without jump_en is ignored (no push).
//     flush_en: count<=0, ptr<=0 (stack invalidated), ras_ovf unchanged.
//   ras_ovf clears only on reset.
//   No X on outputs after reset; target buses are not checked for alignment.
// TESTING
//   Reset: RST=1 mid-run with PC=0x40 -> pc_out=0 immediately, ras_count=0.
//   Sequential+stall: 3 edges pcWEN=1, 2 edges pcWEN=0 -> PC 4,8,C,C,C.
//   Priority: flush_en, ret_en, jump_en, branch_en together, flush_target=
//     0x80 -> PC=0x80; drop flush -> ret wins; drop ret -> jump wins.
//   Call/return: PC=0x10 JAL to 0x100 -> RAS top 0x14, count=1; JR $31
//     with ret_fallback=0xDEAD -> PC=0x14, count=0.
//   Overflow: 5 nested JALs (RAS_DEPTH=4) -> count=4, ras_ovf=1; 5 returns
//     -> first 4 from RAS (newest first), 5th uses ret_fallback.
//   Flush mid-stack with count=2 and pcWEN=0 -> PC=flush_target, count=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirect selection and a
// circular return-address stack so JR $31 resolves at fetch.
module pc_sequencer #(
    parameter int unsigned           WORD_W    = 32,
    parameter logic [WORD_W-1:0]     PC_RESET  = '0,
    parameter logic [WORD_W-1:0]     PC_INC    = WORD_W'(4),
    parameter int unsigned           RAS_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          pcWEN,
    input  logic                          flush_en,
    input  logic [WORD_W-1:0]             flush_target,
    input  logic                          ret_en,
    input  logic [WORD_W-1:0]             ret_fallback,
    input  logic                          jump_en,
    input  logic [WORD_W-1:0]             jump_target,
    input  logic                          call_en,
    input  logic                          branch_en,
    input  logic [WORD_W-1:0]             branch_target,
    output logic [WORD_W-1:0]             pc_out,
    output logic [WORD_W-1:0]             pc_plus,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_ovf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] ras_mem_q [RAS_DEPTH];

    logic              push;
    logic              ras_empty;
    logic              ras_full;
    logic [PTR_W-1:0]  top_idx;

    assign pc_plus   = pc_q + PC_INC;
    assign pc_out    = pc_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_idx   = ptr_q - PTR_W'(1);

    // Next-PC selection and stack bookkeeping; flush overrides the stall.
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        push  = 1'b0;
        if (flush_en) begin
            pc_d  = flush_target;
            ptr_d = '0;
            cnt_d = '0;
        end else if (pcWEN) begin
            if (ret_en) begin
                if (!ras_empty) begin
                    pc_d  = ras_mem_q[top_idx];
                    ptr_d = top_idx;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pc_d = ret_fallback;
                end
            end else if (jump_en) begin
                pc_d = jump_target;
                if (call_en) begin
                    push  = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                    // A full stack keeps its count; the oldest slot is reused.
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else if (branch_en) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= PC_RESET;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Stack storage is never read before being written, so it has no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            ras_mem_q[ptr_q] <= pc_plus;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a queue-based model of the PC and return stack.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pcWEN, flush_en, ret_en, jump_en, call_en, branch_en;
    logic [31:0] flush_target, ret_fallback, jump_target, branch_target;
    logic [31:0] pc_out, pc_plus;
    logic [2:0]  ras_count;
    logic        ras_ovf;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_ovf;
    logic [31:0] m_stack[$];

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .pcWEN(pcWEN),
        .flush_en(flush_en), .flush_target(flush_target),
        .ret_en(ret_en), .ret_fallback(ret_fallback),
        .jump_en(jump_en), .jump_target(jump_target),
        .call_en(call_en), .branch_en(branch_en), .branch_target(branch_target),
        .pc_out(pc_out), .pc_plus(pc_plus),
        .ras_count(ras_count), .ras_ovf(ras_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        pcWEN = 1'b0; flush_en = 1'b0; ret_en = 1'b0; jump_en = 1'b0;
        call_en = 1'b0; branch_en = 1'b0;
        flush_target = '0; ret_fallback = '0; jump_target = '0; branch_target = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        m_pc = '0; m_ovf = 1'b0; m_stack.delete();
    endtask

    // Spec-level effect of one rising edge on the model.
    task automatic model_edge();
        if (flush_en) begin
            m_pc = flush_target;
            m_stack.delete();
        end else if (pcWEN) begin
            if (ret_en) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else m_pc = ret_fallback;
            end else if (jump_en) begin
                if (call_en) begin
                    m_stack.push_back(m_pc + 32'd4);
                    if (m_stack.size() > 4) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1'b1;
                    end
                end
                m_pc = jump_target;
            end else if (branch_en) begin
                m_pc = branch_target;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        repeat (2) tick();
        checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc got %h exp 0", pc_out); else passed++;
        checks++; if (ras_count !== 3'd0) $display("FAIL reset_cnt got %0d exp 0", ras_count); else passed++;
        checks++; if (ras_ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ras_ovf); else passed++;
        checks++; if (pc_plus !== 32'h4) $display("FAIL reset_pc_plus got %h exp 4", pc_plus); else passed++;
        RST = 1'b0;
        pcWEN = 1'b1;
        jump_en = 1'b1; call_en = 1'b1; jump_target = 32'h3C;
        tick();
        jump_en = 1'b0; call_en = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h40) $display("FAIL reset_prerun_pc got %h exp 40", pc_out); else passed++;
        checks++; if (ras_count !== 3'd1) $display("FAIL reset_prerun_cnt got %0d exp 1", ras_count); else passed++;
        #2 RST = 1'b1;
        #1;
        checks++; if (pc_out !== 32'h0) $display("FAIL reset_async_pc got %h exp 0", pc_out); else passed++;
        checks++; if (ras_count !== 3'd0) $display("FAIL reset_async_cnt got %0d exp 0", ras_count); else passed++;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_seq_stall();
        do_reset();
        pcWEN = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'(4 * i)) $display("FAIL seq_pc%0d got %h exp %h", i, pc_out, 32'(4 * i)); else passed++;
        end
        pcWEN = 1'b0;
        jump_en = 1'b1; branch_en = 1'b1; ret_en = 1'b1; call_en = 1'b1;
        jump_target = 32'h700; branch_target = 32'h800; ret_fallback = 32'h900;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_out !== 32'hC) $display("FAIL stall_pc%0d got %h exp c", i, pc_out); else passed++;
            checks++; if (ras_count !== 3'd0) $display("FAIL stall_cnt%0d got %0d exp 0", i, ras_count); else passed++;
        end
    endtask

    task automatic test_priority();
        do_reset();
        pcWEN = 1'b1;
        flush_en = 1'b1; ret_en = 1'b1; jump_en = 1'b1; branch_en = 1'b1;
        flush_target = 32'h80; ret_fallback = 32'h200;
        jump_target = 32'h300; branch_target = 32'h400;
        tick();
        checks++; if (pc_out !== 32'h80) $display("FAIL prio_flush got %h exp 80", pc_out); else passed++;
        flush_en = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h200) $display("FAIL prio_ret got %h exp 200", pc_out); else passed++;
        ret_en = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h300) $display("FAIL prio_jump got %h exp 300", pc_out); else passed++;
        jump_en = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h400) $display("FAIL prio_branch got %h exp 400", pc_out); else passed++;
        branch_en = 1'b0;
        tick();
        checks++; if (pc_out !== 32'h404) $display("FAIL prio_seq got %h exp 404", pc_out); else passed++;
        flush_en = 1'b1; flush_target = 32'hFFFF_FFFC;
        tick();
        flush_en = 1'b0;
        checks++; if (pc_plus !== 32'h0) $display("FAIL wrap_pc_plus got %h exp 0", pc_plus); else passed++;
        tick();
        checks++; if (pc_out !== 32'h0) $display("FAIL wrap_pc got %h exp 0", pc_out); else passed++;
    endtask

    task automatic test_call_return();
        do_reset();
        pcWEN = 1'b1;
        flush_en = 1'b1; flush_target = 32'h10;
        tick();
        flush_en = 1'b0;
        jump_en = 1'b1; call_en = 1'b1; jump_target = 32'h100;
        tick();
        jump_en = 1'b0; call_en = 1'b0;
        checks++; if (pc_out !== 32'h100) $display("FAIL call_pc got %h exp 100", pc_out); else passed++;
        checks++; if (ras_count !== 3'd1) $display("FAIL call_cnt got %0d exp 1", ras_count); else passed++;
        ret_en = 1'b1; ret_fallback = 32'hDEAD;
        tick();
        ret_en = 1'b0;
        checks++; if (pc_out !== 32'h14) $display("FAIL ret_pc got %h exp 14", pc_out); else passed++;
        checks++; if (ras_count !== 3'd0) $display("FAIL ret_cnt got %0d exp 0", ras_count); else passed++;
        call_en = 1'b1;
        tick();
        call_en = 1'b0;
        checks++; if (pc_out !== 32'h18) $display("FAIL lone_call_pc got %h exp 18", pc_out); else passed++;
        checks++; if (ras_count !== 3'd0) $display("FAIL lone_call_cnt got %0d exp 0", ras_count); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        pcWEN = 1'b1;
        jump_en = 1'b1; call_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            jump_target = 32'(32'h1000 * i);
            tick();
        end
        jump_en = 1'b0; call_en = 1'b0;
        checks++; if (ras_count !== 3'd4) $display("FAIL ovf_cnt got %0d exp 4", ras_count); else passed++;
        checks++; if (ras_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", ras_ovf); else passed++;
        ret_en = 1'b1; ret_fallback = 32'hDEAD;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (pc_out !== 32'(32'h1000 * (4 - k) + 4)) $display("FAIL ovf_ret%0d got %h exp %h", k, pc_out, 32'(32'h1000 * (4 - k) + 4)); else passed++;
            checks++; if (ras_count !== 3'(3 - k)) $display("FAIL ovf_ret_cnt%0d got %0d exp %0d", k, ras_count, 3 - k); else passed++;
        end
        tick();
        ret_en = 1'b0;
        checks++; if (pc_out !== 32'hDEAD) $display("FAIL ovf_fallback got %h exp dead", pc_out); else passed++;
        flush_en = 1'b1; flush_target = 32'h60;
        tick();
        flush_en = 1'b0;
        checks++; if (ras_ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", ras_ovf); else passed++;
    endtask

    task automatic test_flush_mid();
        do_reset();
        pcWEN = 1'b1;
        jump_en = 1'b1; call_en = 1'b1;
        jump_target = 32'h500; tick();
        jump_target = 32'h600; tick();
        jump_en = 1'b0; call_en = 1'b0;
        checks++; if (ras_count !== 3'd2) $display("FAIL flush_pre_cnt got %0d exp 2", ras_count); else passed++;
        pcWEN = 1'b0; flush_en = 1'b1; flush_target = 32'h900;
        tick();
        flush_en = 1'b0;
        checks++; if (pc_out !== 32'h900) $display("FAIL flush_pc got %h exp 900", pc_out); else passed++;
        checks++; if (ras_count !== 3'd0) $display("FAIL flush_cnt got %0d exp 0", ras_count); else passed++;
        checks++; if (ras_ovf !== 1'b0) $display("FAIL flush_ovf got %b exp 0", ras_ovf); else passed++;
        pcWEN = 1'b1; ret_en = 1'b1; ret_fallback = 32'hBEEF;
        tick();
        ret_en = 1'b0;
        checks++; if (pc_out !== 32'hBEEF) $display("FAIL flush_ret_pc got %h exp beef", pc_out); else passed++;
        jump_en = 1'b1; call_en = 1'b1; jump_target = 32'hA00;
        tick();
        jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b1;
        tick();
        ret_en = 1'b0;
        checks++; if (pc_out !== 32'hBEF3) $display("FAIL flush_repush got %h exp bef3", pc_out); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            pcWEN         = ($urandom_range(3) != 0);
            flush_en      = ($urandom_range(15) == 0);
            ret_en        = ($urandom_range(4) == 0);
            jump_en       = ($urandom_range(3) == 0);
            call_en       = ($urandom_range(1) == 0);
            branch_en     = ($urandom_range(3) == 0);
            flush_target  = $urandom() & 32'hFFFF_FFFC;
            ret_fallback  = $urandom() & 32'hFFFF_FFFC;
            jump_target   = $urandom() & 32'hFFFF_FFFC;
            branch_target = $urandom() & 32'hFFFF_FFFC;
            model_edge();
            tick();
            checks++; if (pc_out !== m_pc) $display("FAIL rnd_pc cyc %0d got %h exp %h", n, pc_out, m_pc); else passed++;
            checks++; if (pc_plus !== m_pc + 32'd4) $display("FAIL rnd_pc_plus cyc %0d got %h exp %h", n, pc_plus, m_pc + 32'd4); else passed++;
            checks++; if (ras_count !== 3'(m_stack.size())) $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, ras_count, m_stack.size()); else passed++;
            checks++; if (ras_ovf !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %b exp %b", n, ras_ovf, m_ovf); else passed++;
        end
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        test_reset();
        test_seq_stall();
        test_priority();
        test_call_return();
        test_overflow();
        test_flush_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
